// File: rtl/mpsoc_dbg_wb_slave_mem.sv
// mpsoc_dbg_wb_slave_mem
// Wishbone B3 slave backed by a small byte-lane-writable RAM. Serves classic
// single cycles (one transfer every two cycles) and registered-feedback
// incrementing bursts (linear, wrap4, wrap8, wrap16) with one beat per cycle.
// Any access whose word index is DEPTH or more is answered with wb_err_o.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   wb_cyc_i, wb_stb_i, wb_we_i  cycle / strobe / write enable
//   wb_sel_i                     byte lane enables
//   wb_adr_i                     byte address
//   wb_dat_i / wb_dat_o          write data / read data (held between reads)
//   wb_cti_i, wb_bte_i           cycle type / burst type
//   wb_ack_o, wb_err_o           normal / error termination (registered)
module mpsoc_dbg_wb_slave_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_ni,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_we_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic [2:0]              wb_cti_i,
   input  logic [1:0]              wb_bte_i,
   output logic                    wb_ack_o,
   output logic                    wb_err_o
);

   localparam int SEL_W  = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(SEL_W);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int FULL_W = ADDR_WIDTH - OFF_W;

   typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

   state_t                  state_q, state_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d;
   // One extra bit so a linear burst running off the top of the RAM is
   // visible as an out-of-range index rather than silently wrapping to 0.
   logic [IDX_W:0]          badr_q, badr_d;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    mem_we;
   logic [IDX_W-1:0]        mem_idx;

   logic                    req;
   logic [FULL_W-1:0]       adr_word;
   logic                    adr_ok;
   logic                    badr_ok;
   logic                    burst_go;
   logic                    unused_lo;

   assign req       = wb_cyc_i & wb_stb_i;
   assign adr_word  = wb_adr_i[ADDR_WIDTH-1:OFF_W];
   assign adr_ok    = (adr_word >> IDX_W) == '0;
   assign badr_ok   = ~badr_q[IDX_W];
   assign burst_go  = (wb_cti_i == 3'b010);
   assign unused_lo = ^(wb_adr_i & ADDR_WIDTH'(SEL_W - 1));

   // Linear: plain increment. WrapN: only the low log2(N) bits count, the
   // rest of the address (including the overflow bit) is left untouched.
   function automatic logic [IDX_W:0] next_adr(input logic [IDX_W:0] a,
                                                input logic [1:0]   bte);
      logic [IDX_W:0] m;
      case (bte)
         2'b01:   m = (IDX_W+1)'(3);
         2'b10:   m = (IDX_W+1)'(7);
         2'b11:   m = (IDX_W+1)'(15);
         default: m = '1;
      endcase
      return (a & ~m) | ((a + (IDX_W+1)'(1)) & m);
   endfunction

   // State register
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         badr_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         badr_q  <= badr_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      if (!wb_cyc_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (wb_stb_i) state_d = (adr_ok && burst_go) ? BURST : CLASSIC;
            CLASSIC: state_d = IDLE;
            // Any cycle type other than "incrementing" ends the burst, as
            // does running into an out-of-range index.
            BURST:   if (wb_stb_i && (!badr_ok || !burst_go)) state_d = CLASSIC;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs, burst address and memory port
   always_comb begin
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = dat_q;
      badr_d  = badr_q;
      mem_we  = 1'b0;
      mem_idx = adr_word[IDX_W-1:0];
      if (req) begin
         case (state_q)
            IDLE: begin
               if (!adr_ok) begin
                  err_d = 1'b1;
               end else begin
                  ack_d  = 1'b1;
                  mem_we = wb_we_i;
                  if (!wb_we_i) dat_d = mem[mem_idx];
                  if (burst_go) badr_d = next_adr({1'b0, adr_word[IDX_W-1:0]}, wb_bte_i);
               end
            end
            BURST: begin
               mem_idx = badr_q[IDX_W-1:0];
               if (!badr_ok) begin
                  err_d = 1'b1;
               end else begin
                  ack_d  = 1'b1;
                  mem_we = wb_we_i;
                  if (!wb_we_i) dat_d = mem[mem_idx];
                  badr_d = next_adr(badr_q, wb_bte_i);
               end
            end
            default: ;
         endcase
      end
   end

   // RAM is not reset; gating with the reset input keeps a beat that is
   // in flight when reset asserts from landing in memory.
   always_ff @(posedge wb_clk_i) begin
      if (mem_we && wb_rst_ni) begin
         for (int b = 0; b < SEL_W; b++) begin
            if (wb_sel_i[b]) mem[mem_idx][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
         end
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_dat_o = dat_q;

endmodule
